mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: round-robin sharing of the single memory_unit command port among NUM_REQ requesters, with GC hold and retry.
// Latency: grant is registered in IDLE, mem_execute follows 1 cycle later; rsp_valid follows mem_is_ready by 1 cycle.
// Backpressure: requesters hold req_valid until req_ack; no grant while memory is initialising, busy or collecting.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   req_valid/req_func/req_addr1/req_addr2/req_wdata : per-requester command, packed slice i per requester
//   req_ack, rsp_valid                                : one-hot single-cycle pulses to the granted requester
//   rsp_data1/rsp_data2/rsp_free_addr                 : results of the last completed command
//   gc_active, gc_root_valid, gc_root                 : garbage-collection status and new root
//   mem_*                                             : memory_unit command/handshake interface
module mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_func,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr2,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data1,
    output logic [DATA_W-1:0]         rsp_data2,
    output logic [ADDR_W-1:0]         rsp_free_addr,
    output logic                      gc_active,
    output logic                      gc_root_valid,
    output logic [DATA_W-1:0]         gc_root,
    output logic [1:0]                mem_func,
    output logic                      mem_execute,
    output logic [ADDR_W-1:0]         mem_address1,
    output logic [ADDR_W-1:0]         mem_address2,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_gc_ready,
    input  logic                      mem_is_ready,
    input  logic                      mem_gc,
    input  logic [DATA_W-1:0]         mem_read_data1,
    input  logic [DATA_W-1:0]         mem_read_data2,
    input  logic [ADDR_W-1:0]         mem_free_addr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GC_HOLD,
        RESPOND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_found;
    logic [PTR_W:0]    cand;

    logic [PTR_W-1:0]  lat_g;
    logic [1:0]        lat_func;
    logic [ADDR_W-1:0] lat_addr1;
    logic [ADDR_W-1:0] lat_addr2;
    logic [DATA_W-1:0] lat_wdata;

    // gc_retry: the collection interrupted a latched command that must be reissued.
    // gc_done : mem_gc has fallen; waiting for mem_is_ready before leaving GC_HOLD.
    logic              gc_retry;
    logic              gc_done;

    // Unpacked views of the per-requester buses so the grant index selects a whole field.
    logic [1:0]        func_arr  [NUM_REQ];
    logic [ADDR_W-1:0] addr1_arr [NUM_REQ];
    logic [ADDR_W-1:0] addr2_arr [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign func_arr[i]  = req_func[2*i +: 2];
        assign addr1_arr[i] = req_addr1[ADDR_W*i +: ADDR_W];
        assign addr2_arr[i] = req_addr2[ADDR_W*i +: ADDR_W];
        assign wdata_arr[i] = req_wdata[DATA_W*i +: DATA_W];
    end

    // Scan requesters starting at rr_ptr; the candidate index wraps with a
    // single subtraction because rr_ptr + i is always below 2*NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A collection starting while idle is serviced without any retry.
                if (mem_gc) begin
                    state_nxt = GC_HOLD;
                end else if (mem_is_ready && grant_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mem_gc) begin
                    state_nxt = GC_HOLD;
                end else if (mem_is_ready) begin
                    state_nxt = RESPOND;
                end
            end
            GC_HOLD: begin
                if (gc_done && !mem_gc && mem_is_ready) begin
                    state_nxt = gc_retry ? ISSUE : IDLE;
                end
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lat_g         <= '0;
            lat_func      <= '0;
            lat_addr1     <= '0;
            lat_addr2     <= '0;
            lat_wdata     <= '0;
            gc_retry      <= 1'b0;
            gc_done       <= 1'b0;
            req_ack       <= '0;
            rsp_data1     <= '0;
            rsp_data2     <= '0;
            rsp_free_addr <= '0;
            gc_root_valid <= 1'b0;
            gc_root       <= '0;
        end else begin
            state         <= state_nxt;
            req_ack       <= '0;
            gc_root_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_gc) begin
                        gc_retry <= 1'b0;
                        gc_done  <= 1'b0;
                    end else if (mem_is_ready && grant_found) begin
                        lat_g     <= grant_idx;
                        lat_func  <= func_arr[grant_idx];
                        lat_addr1 <= addr1_arr[grant_idx];
                        lat_addr2 <= addr2_arr[grant_idx];
                        lat_wdata <= wdata_arr[grant_idx];
                        req_ack   <= NUM_REQ'(1) << grant_idx;
                    end
                end
                WAIT_DONE: begin
                    if (mem_gc) begin
                        gc_retry <= 1'b1;
                        gc_done  <= 1'b0;
                    end else if (mem_is_ready) begin
                        rsp_data1     <= mem_read_data1;
                        rsp_data2     <= mem_read_data2;
                        rsp_free_addr <= mem_free_addr;
                    end
                end
                GC_HOLD: begin
                    if (!gc_done && !mem_gc) begin
                        gc_done       <= 1'b1;
                        gc_root       <= mem_read_data1;
                        gc_root_valid <= 1'b1;
                    end else if (gc_done && mem_gc) begin
                        // Back-to-back collection: wait for the next falling edge.
                        gc_done <= 1'b0;
                    end
                end
                RESPOND: begin
                    rr_ptr <= (lat_g == PTR_W'(NUM_REQ-1)) ? '0 : lat_g + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Command fields come straight from the latch, so they stay stable from
    // ISSUE through RESPOND (and across a GC retry) without extra registers.
    assign mem_func       = lat_func;
    assign mem_address1   = lat_addr1;
    assign mem_address2   = lat_addr2;
    assign mem_write_data = lat_wdata;
    assign mem_execute    = (state == ISSUE);
    assign gc_active      = (state == GC_HOLD) && !gc_done;
    assign mem_gc_ready   = gc_active && mem_gc;
    assign rsp_valid      = (state == RESPOND) ? (NUM_REQ'(1) << lat_g) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: bench for mem_arbiter with a behavioural memory_unit and a round-robin/result reference model.
// Latency: memory completes 1..3 cycles after execute; garbage collection takes a few gc_ready cycles.
// Backpressure: requester queues hold req_valid until req_ack; memory holds is_ready low while busy.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 64;

    localparam logic [1:0] F_GET  = 2'd0;
    localparam logic [1:0] F_SET  = 2'd1;
    localparam logic [1:0] F_FREE = 2'd2;

    localparam int          MEM_LIMIT = 1024;
    localparam int          GC_BASE   = 'h100;
    localparam logic [63:0] GC_ROOT   = 64'h0000_0000_0BAD_F00D;
    localparam int          INIT_CYC  = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [2*N-1:0]  req_func  = '0;
    logic [AW*N-1:0] req_addr1 = '0;
    logic [AW*N-1:0] req_addr2 = '0;
    logic [DW*N-1:0] req_wdata = '0;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data1;
    logic [DW-1:0]   rsp_data2;
    logic [AW-1:0]   rsp_free_addr;
    logic            gc_active;
    logic            gc_root_valid;
    logic [DW-1:0]   gc_root;
    logic [1:0]      mem_func;
    logic            mem_execute;
    logic [AW-1:0]   mem_address1;
    logic [AW-1:0]   mem_address2;
    logic [DW-1:0]   mem_write_data;
    logic            mem_gc_ready;
    logic            mem_is_ready   = 1'b0;
    logic            mem_gc         = 1'b0;
    logic [DW-1:0]   mem_read_data1 = '0;
    logic [DW-1:0]   mem_read_data2 = '0;
    logic [AW-1:0]   mem_free_addr  = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_func(req_func), .req_addr1(req_addr1),
        .req_addr2(req_addr2), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data1(rsp_data1),
        .rsp_data2(rsp_data2), .rsp_free_addr(rsp_free_addr),
        .gc_active(gc_active), .gc_root_valid(gc_root_valid), .gc_root(gc_root),
        .mem_func(mem_func), .mem_execute(mem_execute), .mem_address1(mem_address1),
        .mem_address2(mem_address2), .mem_write_data(mem_write_data),
        .mem_gc_ready(mem_gc_ready), .mem_is_ready(mem_is_ready), .mem_gc(mem_gc),
        .mem_read_data1(mem_read_data1), .mem_read_data2(mem_read_data2),
        .mem_free_addr(mem_free_addr)
    );

    typedef struct packed {
        logic [1:0]    func;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] wd;
    } cmd_t;

    int checks = 0;
    int errors = 0;

    cmd_t rq [N][$];

    // memory_unit model state
    logic [63:0] mem [0:MEM_LIMIT-1];
    int          free_ptr = 'h300;
    int          init_cnt = INIT_CYC;
    int          busy_cnt = 0;
    int          gc_wait  = 0;
    bit          gc_phase = 1'b0;
    bit          mem_init_done = 1'b0;
    bit          slow = 1'b0;
    cmd_t        mc;

    // reference model / monitor state
    bit          inflight = 1'b0;
    int          infl_g = 0;
    cmd_t        infl_cmd;
    logic [63:0] exp_d1, exp_d2;
    logic [AW-1:0] exp_fa;
    bit          exp_gc = 1'b0;
    int          infl_exec = 0;
    int          last_exec = 0;
    int          rr_model = 0;
    int          ref_free = 'h300;
    int          rsp_cnt [N] = '{default: 0};
    int          acks_total = 0;
    int          gc_active_cyc = 0;
    int          gc_ready_cyc = 0;
    int          root_pulses = 0;
    int          grant_log [$];

    function automatic logic [63:0] pat(input int a);
        return {32'hA5A5_0000 + 32'(a), 32'(a) * 32'h0101_0101};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [1:0] f, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] wd);
        cmd_t c;
        c.func = f;
        c.a1   = a1;
        c.a2   = a2;
        c.wd   = wd;
        rq[r].push_back(c);
    endtask

    task automatic wait_quiet(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((rq[0].size() + rq[1].size() + rq[2].size() != 0 || inflight) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < max_cyc), 64'd1);
        @(negedge clk);
        #1;
    endtask

    // Behavioural memory_unit: updates at the falling edge, so the arbiter
    // sees every change at the following rising edge.
    initial begin
        for (int a = 0; a < MEM_LIMIT; a++) mem[a] = pat(a);
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_is_ready  = 1'b0;
                mem_gc        = 1'b0;
                init_cnt      = INIT_CYC;
                busy_cnt      = 0;
                gc_phase      = 1'b0;
                mem_init_done = 1'b0;
            end else if (init_cnt > 0) begin
                init_cnt--;
                if (init_cnt == 0) begin
                    mem_is_ready  = 1'b1;
                    mem_init_done = 1'b1;
                end
            end else if (gc_phase) begin
                if (mem_gc_ready) gc_wait++;
                if (gc_wait >= 3) begin
                    mem_gc         = 1'b0;
                    gc_phase       = 1'b0;
                    free_ptr       = GC_BASE;
                    mem_read_data1 = GC_ROOT;
                    mem_is_ready   = 1'b1;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    case (mc.func)
                        F_GET: begin
                            mem_read_data1 = mem[mc.a1];
                            mem_read_data2 = mem[mc.a2];
                            mem_is_ready   = 1'b1;
                        end
                        F_SET: begin
                            mem[mc.a1]   = mc.wd;
                            mem_is_ready = 1'b1;
                        end
                        F_FREE: begin
                            if (free_ptr + int'(mc.wd) > MEM_LIMIT) begin
                                mem_gc   = 1'b1;
                                gc_phase = 1'b1;
                                gc_wait  = 0;
                            end else begin
                                mem_free_addr = AW'(free_ptr);
                                free_ptr      = free_ptr + int'(mc.wd);
                                mem_is_ready  = 1'b1;
                            end
                        end
                        default: mem_is_ready = 1'b1;
                    endcase
                end
            end else if (mem_execute) begin
                mc.func      = mem_func;
                mc.a1        = mem_address1;
                mc.a2        = mem_address2;
                mc.wd        = mem_write_data;
                mem_is_ready = 1'b0;
                busy_cnt     = slow ? 20 : int'($urandom_range(1, 3));
            end
        end
    end

    // Requester driver and reference checker.
    initial begin
        int   exp_g;
        int   g;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                inflight = 1'b0;
                rr_model = 0;
                check("rsp_in_reset", 64'(rsp_valid), 64'd0);
            end else begin
                if (req_ack != '0) begin
                    acks_total++;
                    exp_g = -1;
                    for (int k = 0; k < N; k++) begin
                        if (exp_g < 0 && req_valid[(rr_model + k) % N]) exp_g = (rr_model + k) % N;
                    end
                    g = -1;
                    for (int k = N - 1; k >= 0; k--) if (req_ack[k]) g = k;
                    check("ack_onehot", 64'($countones(req_ack)), 64'd1);
                    check("ack_after_init", 64'(mem_init_done), 64'd1);
                    check("ack_while_busy", 64'(inflight), 64'd0);
                    check("grant_rr", 64'(g), 64'(exp_g));
                    if (g >= 0 && rq[g].size() > 0) begin
                        c         = rq[g].pop_front();
                        infl_cmd  = c;
                        infl_g    = g;
                        inflight  = 1'b1;
                        infl_exec = 0;
                        exp_gc    = 1'b0;
                        exp_d1    = mem[c.a1];
                        exp_d2    = mem[c.a2];
                        if (c.func == F_FREE) begin
                            if (ref_free + int'(c.wd) > MEM_LIMIT) begin
                                exp_gc   = 1'b1;
                                ref_free = GC_BASE;
                            end
                            exp_fa   = AW'(ref_free);
                            ref_free = ref_free + int'(c.wd);
                        end
                        grant_log.push_back(g);
                    end
                end
                if (mem_execute) begin
                    check("exec_owned", 64'(inflight), 64'd1);
                    infl_exec++;
                end
                if (gc_active) gc_active_cyc++;
                if (mem_gc_ready) gc_ready_cyc++;
                if (gc_root_valid) begin
                    root_pulses++;
                    check("gc_root", gc_root, GC_ROOT);
                end
                if (rsp_valid != '0) begin
                    check("rsp_expected", 64'(inflight), 64'd1);
                    check("rsp_target", 64'(rsp_valid), 64'(N'(1) << infl_g));
                    check("exec_count", 64'(infl_exec), exp_gc ? 64'd2 : 64'd1);
                    if (infl_cmd.func == F_GET) begin
                        check("rsp_data1", rsp_data1, exp_d1);
                        check("rsp_data2", rsp_data2, exp_d2);
                    end
                    if (infl_cmd.func == F_FREE) check("rsp_free_addr", 64'(rsp_free_addr), 64'(exp_fa));
                    last_exec = infl_exec;
                    rsp_cnt[infl_g]++;
                    rr_model = (infl_g + 1) % N;
                    inflight = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    c = rq[i][0];
                    req_valid[i]            = 1'b1;
                    req_func[2*i +: 2]      = c.func;
                    req_addr1[AW*i +: AW]   = c.a1;
                    req_addr2[AW*i +: AW]   = c.a2;
                    req_wdata[DW*i +: DW]   = c.wd;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int snap;
        int r;
        int sel;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_execute", 64'(mem_execute), 64'd0);
        check("rst_mem_gc_ready", 64'(mem_gc_ready), 64'd0);
        check("rst_gc_active", 64'(gc_active), 64'd0);
        check("rst_gc_root_valid", 64'(gc_root_valid), 64'd0);
        check("rst_mem_func", 64'(mem_func), 64'd0);
        check("rst_mem_address1", 64'(mem_address1), 64'd0);
        check("rst_mem_write_data", mem_write_data, 64'd0);
        check("rst_rsp_data1", rsp_data1, 64'd0);

        // Single read, requested while memory is still initialising.
        push(0, F_GET, 10'h005, 10'h006, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!mem_init_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("init_done_seen", 64'(mem_init_done), 64'd1);
        check("init_no_ack", 64'(acks_total), 64'd0);
        wait_quiet(200, "single_read_done");
        check("single_exec_pulses", 64'(last_exec), 64'd1);
        check("single_rsp_count", 64'(rsp_cnt[0]), 64'd1);
        check("single_data1", rsp_data1, pat(5));
        check("single_data2", rsp_data2, pat(6));

        // Contention from reset: all three pending twice each.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            push(i, F_GET, AW'(8 + i), AW'(20 + i), 64'd0);
            push(i, F_GET, AW'(11 + i), AW'(23 + i), 64'd0);
        end
        grant_log.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_quiet(400, "contention_done");
        check("contention_grants", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) check("contention_order", 64'(grant_log[k]), 64'(k % N));

        // Write then read.
        push(1, F_SET, 10'h010, 10'h000, 64'hDEAD_BEEF);
        wait_quiet(200, "write_done");
        push(2, F_GET, 10'h010, 10'h011, 64'd0);
        wait_quiet(200, "read_done");
        check("wr_rd_data1", rsp_data1, 64'hDEAD_BEEF);

        // GET_FREE without and with garbage collection.
        push(0, F_FREE, 10'h000, 10'h000, 64'h10);
        wait_quiet(200, "free_small_done");
        check("free_small_addr", 64'(rsp_free_addr), 64'h300);
        gc_active_cyc = 0;
        gc_ready_cyc  = 0;
        root_pulses   = 0;
        snap = rsp_cnt[1];
        push(1, F_FREE, 10'h000, 10'h000, 64'h200);
        wait_quiet(400, "free_gc_done");
        check("gc_active_seen", 64'(gc_active_cyc > 0), 64'd1);
        check("gc_ready_seen", 64'(gc_ready_cyc > 0), 64'd1);
        check("gc_root_pulses", 64'(root_pulses), 64'd1);
        check("gc_exec_pulses", 64'(last_exec), 64'd2);
        check("gc_rsp_count", 64'(rsp_cnt[1] - snap), 64'd1);
        check("gc_free_addr", 64'(rsp_free_addr), 64'(GC_BASE));
        check("gc_active_after", 64'(gc_active), 64'd0);

        // Reset while waiting for the memory to complete.
        slow = 1'b1;
        snap = rsp_cnt[2];
        push(2, F_GET, 10'h007, 10'h008, 64'd0);
        n = 0;
        while (!inflight && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_inflight", 64'(inflight), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_mem_execute", 64'(mem_execute), 64'd0);
        check("midrst_mem_func_addr", 64'({mem_func, mem_address1, mem_address2}), 64'd0);
        check("midrst_write_data", mem_write_data, 64'd0);
        check("midrst_rsp_data1", rsp_data1, 64'd0);
        check("midrst_free_addr", 64'(rsp_free_addr), 64'd0);
        check("midrst_ack_rsp", 64'({req_ack, rsp_valid}), 64'd0);
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (3) @(negedge clk);
        slow = 1'b0;
        rst  = 1'b1;
        check("midrst_no_rsp", 64'(rsp_cnt[2] - snap), 64'd0);
        push(2, F_GET, 10'h009, 10'h00A, 64'd0);
        wait_quiet(300, "post_reset_done");
        check("post_reset_rsp", 64'(rsp_cnt[2] - snap), 64'd1);
        check("post_reset_data1", rsp_data1, pat(9));

        // Randomised traffic checked by the reference model.
        for (int t = 0; t < 60; t++) begin
            r   = int'($urandom_range(0, N - 1));
            sel = int'($urandom_range(0, 9));
            if (rq[r].size() < 2) begin
                if (sel < 5)
                    push(r, F_GET, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), 64'd0);
                else if (sel < 8)
                    push(r, F_SET, AW'($urandom_range(0, 31)), 10'h000, {$urandom, $urandom});
                else
                    push(r, F_FREE, 10'h000, 10'h000, 64'($urandom_range(1, 8)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_quiet(3000, "random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
